// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: registered fetch redirect plus multi-cycle flush.
// Optional BRANCH_STATS_EN adds saturating branch / taken-branch counters.
module branch_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    output logic        b_taken,
    output logic [31:0] b_pc,
    output logic [31:0] link_addr,
    output logic        flush,
    output logic        busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        b_taken_d;
    logic [31:0] b_pc_d;
    logic [31:0] link_d;

    logic        sel_jalr, sel_jal, sel_br;
    logic        cond_met;
    logic        taken;
    logic        accept;
    logic [31:0] target;
    logic [31:0] pc_plus_imm;
    logic [31:0] rs1_plus_imm;
    logic [31:0] pc_plus_4;

    // JALR wins over JAL, which wins over a conditional branch.
    always_comb begin
        sel_jalr = is_jalr;
        sel_jal  = is_jal & ~is_jalr;
        sel_br   = is_branch & ~is_jal & ~is_jalr;
    end

    always_comb begin
        cond_met = 1'b0;
        case (funct3)
            3'b000:  cond_met = (rs1_val == rs2_val);
            3'b001:  cond_met = (rs1_val != rs2_val);
            3'b100:  cond_met = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  cond_met = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  cond_met = (rs1_val <  rs2_val);
            3'b111:  cond_met = (rs1_val >= rs2_val);
            default: cond_met = 1'b0;
        endcase
    end

    always_comb begin
        pc_plus_imm  = pc + imm;
        rs1_plus_imm = rs1_val + imm;
        pc_plus_4    = pc + 32'd4;
        target       = sel_jalr ? (rs1_plus_imm & ~32'h1) : pc_plus_imm;
        taken        = sel_jalr | sel_jal | (sel_br & cond_met);
        accept       = in_valid & (state_q == IDLE);
    end

    // Next-state: a taken instruction arms the redirect pulse and the flush window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_taken_d = 1'b0;
        b_pc_d    = b_pc;
        link_d    = link_addr;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_jalr || sel_jal) begin
                        link_d = pc_plus_4;
                    end
                    if (taken) begin
                        b_taken_d = 1'b1;
                        b_pc_d    = target;
                        state_d   = FLUSH;
                        cnt_d     = CNT_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            b_taken   <= 1'b0;
            b_pc      <= 32'd0;
            link_addr <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_taken   <= b_taken_d;
            b_pc      <= b_pc_d;
            link_addr <= link_d;
        end
    end

    assign flush = (state_q == FLUSH);
    assign busy  = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    // Counters only see instructions actually accepted as conditional branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count       <= 32'd0;
            br_taken_count <= 32'd0;
        end else if (accept && sel_br) begin
            if (br_count != 32'hFFFF_FFFF) begin
                br_count <= br_count + 32'd1;
            end
            if (cond_met && (br_taken_count != 32'hFFFF_FFFF)) begin
                br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: vector table plus hand-written multi-cycle sequences.
// Stats checks are compiled only when BRANCH_STATS_EN is defined.
module tb_branch_resolve;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        b_taken;
    logic [31:0] b_pc;
    logic [31:0] link_addr;
    logic        flush;
    logic        busy;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] br_taken_count;
`endif

    int checks;
    int failures;

    typedef struct {
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic [31:0] exp_link;
    } vec_t;

    vec_t vecs[13];

    branch_resolve #(.FLUSH_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .is_branch(is_branch),
        .is_jal(is_jal),
        .is_jalr(is_jalr),
        .funct3(funct3),
        .pc(pc),
        .rs1_val(rs1_val),
        .rs2_val(rs2_val),
        .imm(imm),
        .b_taken(b_taken),
        .b_pc(b_pc),
        .link_addr(link_addr),
        .flush(flush),
        .busy(busy)
`ifdef BRANCH_STATS_EN
        ,
        .br_count(br_count),
        .br_taken_count(br_taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                                 input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im);
        in_valid  = 1'b1;
        is_branch = br;
        is_jal    = jal;
        is_jalr   = jalr;
        funct3    = f3;
        pc        = p;
        rs1_val   = a;
        rs2_val   = b;
        imm       = im;
    endtask

    task automatic idleInputs();
        in_valid  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        funct3    = 3'b000;
        pc        = 32'd0;
        rs1_val   = 32'd0;
        rs2_val   = 32'd0;
        imm       = 32'd0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idleInputs();

        //            br    jal   jalr  f3      pc            rs1           rs2           imm           tk    b_pc          link
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h100,      32'd5,        32'd5,        32'h20,       1'b1, 32'h120,      32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h300,      32'hFFFFFFFF, 32'd1,        32'h10,       1'b1, 32'h310,      32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b110, 32'h400,      32'hFFFFFFFF, 32'd1,        32'h10,       1'b0, 32'h310,      32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h200,      32'h1003,     32'd0,        32'h0,        1'b1, 32'h1002,     32'h204};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFFFFFC, 32'd0,        32'd0,        32'h8,        1'b1, 32'h4,        32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'h500,      32'd1,        32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1, 32'h4F0,      32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b111, 32'h500,      32'd1,        32'hFFFFFFFF, 32'h40,       1'b0, 32'h4F0,      32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h500,      32'd7,        32'd7,        32'h40,       1'b0, 32'h4F0,      32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h500,      32'd0,        32'd0,        32'h40,       1'b0, 32'h4F0,      32'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'b000, 32'h600,      32'h2000,     32'd9,        32'h4,        1'b1, 32'h2004,     32'h604};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h700,      32'd3,        32'd3,        32'h40,       1'b1, 32'h740,      32'h704};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b000, 32'h900,      32'd1,        32'd1,        32'h40,       1'b0, 32'h740,      32'h704};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'b111, 32'h800,      32'hFFFFFFFF, 32'd1,        32'h8,        1'b1, 32'h808,      32'h704};

        doReset();
        checkOutput("reset_b_taken", 32'(b_taken), 32'd0);
        checkOutput("reset_b_pc", b_pc, 32'd0);
        checkOutput("reset_link", link_addr, 32'd0);
        checkOutput("reset_flush", 32'(flush), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Table vectors, each starting from IDLE.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3,
                          vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            step();
            idleInputs();
            checkOutput($sformatf("vec%0d_b_taken", i), 32'(b_taken), 32'(vecs[i].exp_taken));
            checkOutput($sformatf("vec%0d_b_pc", i), b_pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_link", i), link_addr, vecs[i].exp_link);
            checkOutput($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].exp_taken));
            repeat (3) step();
        end

        // BEQ taken: pulse and flush window timing.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
        step();
        idleInputs();
        checkOutput("seq1_t1_b_taken", 32'(b_taken), 32'd1);
        checkOutput("seq1_t1_b_pc", b_pc, 32'h120);
        checkOutput("seq1_t1_flush", 32'(flush), 32'd1);
        checkOutput("seq1_t1_busy", 32'(busy), 32'd1);
        step();
        checkOutput("seq1_t2_b_taken", 32'(b_taken), 32'd0);
        checkOutput("seq1_t2_flush", 32'(flush), 32'd1);
        checkOutput("seq1_t2_busy", 32'(busy), 32'd1);
        checkOutput("seq1_t2_b_pc_hold", b_pc, 32'h120);
        step();
        checkOutput("seq1_t3_flush", 32'(flush), 32'd0);
        checkOutput("seq1_t3_busy", 32'(busy), 32'd0);
        repeat (2) step();

        // Taken BNE, then a JAL held on in_valid through the flush window.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 32'h900, 32'd1, 32'd2, 32'h100);
        step();
        checkOutput("seq4_bne_taken", 32'(b_taken), 32'd1);
        checkOutput("seq4_bne_pc", b_pc, 32'hA00);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h1000, 32'd0, 32'd0, 32'h40);
        step();
        checkOutput("seq4_f1_no_taken", 32'(b_taken), 32'd0);
        checkOutput("seq4_f1_b_pc", b_pc, 32'hA00);
        step();
        checkOutput("seq4_f2_no_taken", 32'(b_taken), 32'd0);
        checkOutput("seq4_f2_flush", 32'(flush), 32'd0);
        checkOutput("seq4_f2_link", link_addr, 32'h704);
        step();
        idleInputs();
        checkOutput("seq4_jal_taken", 32'(b_taken), 32'd1);
        checkOutput("seq4_jal_pc", b_pc, 32'h1040);
        checkOutput("seq4_jal_link", link_addr, 32'h1004);
        repeat (3) step();

        // Reset during the first flush cycle, then an immediate branch.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
        step();
        idleInputs();
        checkOutput("seq5_pre_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("seq5_rst_flush", 32'(flush), 32'd0);
        checkOutput("seq5_rst_busy", 32'(busy), 32'd0);
        checkOutput("seq5_rst_b_pc", b_pc, 32'd0);
        checkOutput("seq5_rst_b_taken", 32'(b_taken), 32'd0);
        checkOutput("seq5_rst_link", link_addr, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h40, 32'd3, 32'd3, 32'h10);
        step();
        idleInputs();
        checkOutput("seq5_br_taken", 32'(b_taken), 32'd1);
        checkOutput("seq5_br_pc", b_pc, 32'h50);
        repeat (3) step();

`ifdef BRANCH_STATS_EN
        doReset();
        checkOutput("stats_reset_count", br_count, 32'd0);
        checkOutput("stats_reset_taken", br_taken_count, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd1, 32'd1, 32'h20);
        step(); idleInputs(); repeat (3) step();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd1, 32'd2, 32'h20);
        step(); idleInputs(); repeat (3) step();
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'd0, 32'd0, 32'h20);
        step(); idleInputs(); repeat (3) step();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b001, 32'h100, 32'd1, 32'd2, 32'h20);
        step(); idleInputs(); repeat (3) step();
        checkOutput("stats_br_count", br_count, 32'd3);
        checkOutput("stats_br_taken_count", br_taken_count, 32'd2);
        force dut.br_count = 32'hFFFFFFFF;
        #1;
        release dut.br_count;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd1, 32'd2, 32'h20);
        step(); idleInputs();
        checkOutput("stats_saturate", br_count, 32'hFFFFFFFF);
        checkOutput("stats_taken_hold", br_taken_count, 32'd2);
        repeat (3) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
